audio_fx_router: RTL and testbench

- Parametrised successor to the single-effect dry/wet output mux on the audio path.
- Selects among a dry sample stream and N_FX effect outputs, then feeds the result to the DAC driver.
- Source changes are not hard switches: the block performs a linear crossfade over 2^RAMP_LOG2 samples, which removes clicks.
- Sits between the SPI receiver / effect modules and the DAC driver, in the clk_25mhz domain.

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_fx_router_if.sv | 26 ++
 rtl/xfade_mac.sv | 57 +++++
 rtl/audio_fx_router.sv | 152 +++++++++++++++
 tb/tb_audio_fx_router.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio_fx_router codebase slice.
package audio_pkg;

   typedef logic signed [15:0] sample_t;

   typedef enum logic {
      STEADY = 1'b0,
      FADE   = 1'b1
   } router_state_t;

   localparam int SEL_BYPASS = 0;

endpackage

// File: rtl/audio_fx_router_if.sv
// Sample-stream bundle between the effect sources, the router and the DAC driver side.
interface audio_fx_router_if #(
   parameter int DATA_W = 16,
   parameter int N_FX   = 4
);
   localparam int SEL_W = $clog2(N_FX + 1);

   logic                     in_valid;
   logic signed [DATA_W-1:0] dry_in;
   logic [N_FX*DATA_W-1:0]   wet_in;
   logic [SEL_W-1:0]         fx_sel;
   logic                     out_valid;
   logic signed [DATA_W-1:0] audio_out;
   logic                     busy;

   modport master (
      output in_valid, dry_in, wet_in, fx_sel,
      input  out_valid, audio_out, busy
   );

   modport slave (
      input  in_valid, dry_in, wet_in, fx_sel,
      output out_valid, audio_out, busy
   );

endinterface

// File: rtl/xfade_mac.sv
// Two-stage crossfade datapath: y = (a*(M-k) + b*k + M/2) >>> RAMP_LOG2, half-up rounding.
module xfade_mac #(
   parameter int DATA_W    = 16,
   parameter int RAMP_LOG2 = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vld,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic [RAMP_LOG2:0]       k,
   output logic                     out_vld,
   output logic signed [DATA_W-1:0] y
);
   localparam int M  = 1 << RAMP_LOG2;
   localparam int IW = DATA_W + RAMP_LOG2 + 2;
   localparam int KW = RAMP_LOG2 + 1;

   // Weights sum to M, so the shifted result always fits DATA_W without saturation.
   function automatic logic signed [DATA_W-1:0] round_shift(input logic signed [IW-1:0] s);
      return DATA_W'((s + IW'(M / 2)) >>> RAMP_LOG2);
   endfunction

   logic [KW-1:0]           wa;
   logic signed [IW-1:0]    prod_a_p1;
   logic signed [IW-1:0]    prod_b_p1;
   logic                    vld_p1;
   logic signed [DATA_W-1:0] y_p2;
   logic                    vld_p2;

   assign wa = KW'(M) - k;

   // Stage 1: weighted products
   always_ff @(posedge clk) begin
      if (vld) begin
         prod_a_p1 <= IW'(a) * IW'($signed({1'b0, wa}));
         prod_b_p1 <= IW'(b) * IW'($signed({1'b0, k}));
      end
   end

   // Stage 2: rounded sum, held between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         y_p2   <= '0;
      end else begin
         vld_p1 <= vld;
         vld_p2 <= vld_p1;
         if (vld_p1) y_p2 <= round_shift(prod_a_p1 + prod_b_p1);
      end
   end

   assign out_vld = vld_p2;
   assign y       = y_p2;

endmodule

// File: rtl/audio_fx_router.sv
// Dry/effect source router with click-free linear crossfade; optional peak meter
// enabled by defining AUDIO_FX_ROUTER_PEAK_EN.
module audio_fx_router
   import audio_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int N_FX      = 4,
   parameter int RAMP_LOG2 = 6
) (
   input  logic               clk_25mhz,
   input  logic               reset,
   audio_fx_router_if.slave   bus
`ifdef AUDIO_FX_ROUTER_PEAK_EN
   ,
   input  logic               peak_clr,
   output logic [DATA_W-2:0]  peak_out
`endif
);
   localparam int SEL_W = $clog2(N_FX + 1);
   localparam int M     = 1 << RAMP_LOG2;
   localparam int KW    = RAMP_LOG2 + 1;

   logic signed [DATA_W-1:0] srcs [0:N_FX];
   router_state_t            state;
   logic [SEL_W-1:0]         cur_src;
   logic [SEL_W-1:0]         tgt_src;
   logic [SEL_W-1:0]         pend_src;
   logic                     pend_valid;
   logic [KW-1:0]            k;
   logic                     busy_r;
   logic [SEL_W-1:0]         sel_eff;
   logic [SEL_W-1:0]         pend_src_n;
   logic                     pend_valid_n;
   logic signed [DATA_W-1:0] mac_a;
   logic signed [DATA_W-1:0] mac_b;
   logic [KW-1:0]            mac_k;
   logic                     out_valid;
   logic signed [DATA_W-1:0] audio_out;

   always_comb begin
      srcs[0] = bus.dry_in;
      for (int i = 0; i < N_FX; i++) srcs[i+1] = bus.wet_in[i*DATA_W +: DATA_W];
   end

   // Out-of-range selectors fall back to dry; pending request is last-writer-wins.
   always_comb begin
      sel_eff      = (bus.fx_sel > SEL_W'(N_FX)) ? SEL_W'(SEL_BYPASS) : bus.fx_sel;
      pend_valid_n = pend_valid;
      pend_src_n   = pend_src;
      if (state == FADE) begin
         if (sel_eff != tgt_src) begin
            pend_valid_n = 1'b1;
            pend_src_n   = sel_eff;
         end else begin
            pend_valid_n = 1'b0;
         end
      end
      mac_a = srcs[cur_src];
      mac_b = srcs[cur_src];
      mac_k = '0;
      if (state == FADE) begin
         mac_b = srcs[tgt_src];
         mac_k = k;
      end else if (sel_eff != cur_src) begin
         mac_b = srcs[sel_eff];
         mac_k = KW'(1);
      end
   end

   // k holds the weight for the next fading sample; the first fade sample uses k=1.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         state      <= STEADY;
         cur_src    <= SEL_W'(SEL_BYPASS);
         tgt_src    <= SEL_W'(SEL_BYPASS);
         pend_src   <= SEL_W'(SEL_BYPASS);
         pend_valid <= 1'b0;
         k          <= '0;
         busy_r     <= 1'b0;
      end else if (bus.in_valid) begin
         case (state)
            STEADY: begin
               if (sel_eff != cur_src) begin
                  tgt_src <= sel_eff;
                  k       <= KW'(2);
                  state   <= FADE;
                  busy_r  <= 1'b1;
               end
            end
            FADE: begin
               if (k == KW'(M)) begin
                  cur_src    <= tgt_src;
                  pend_valid <= 1'b0;
                  if (pend_valid_n) begin
                     tgt_src <= pend_src_n;
                     k       <= KW'(1);
                     busy_r  <= 1'b1;
                  end else begin
                     state  <= STEADY;
                     k      <= '0;
                     busy_r <= 1'b0;
                  end
               end else begin
                  k          <= k + KW'(1);
                  pend_valid <= pend_valid_n;
                  pend_src   <= pend_src_n;
                  busy_r     <= 1'b1;
               end
            end
            default: state <= STEADY;
         endcase
      end
   end

   xfade_mac #(
      .DATA_W    (DATA_W),
      .RAMP_LOG2 (RAMP_LOG2)
   ) u_mac (
      .clk     (clk_25mhz),
      .rst     (reset),
      .vld     (bus.in_valid),
      .a       (mac_a),
      .b       (mac_b),
      .k       (mac_k),
      .out_vld (out_valid),
      .y       (audio_out)
   );

   assign bus.out_valid = out_valid;
   assign bus.audio_out = audio_out;
   assign bus.busy      = busy_r;

`ifdef AUDIO_FX_ROUTER_PEAK_EN
   // Magnitude of the most negative code saturates to the largest positive one.
   function automatic logic [DATA_W-2:0] abs_sat(input logic signed [DATA_W-1:0] x);
      if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {(DATA_W-1){1'b1}};
      else if (x < 0) return (DATA_W-1)'(-x);
      else return (DATA_W-1)'(x);
   endfunction

   logic [DATA_W-2:0] peak;

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) peak <= '0;
      else if (peak_clr) peak <= '0;
      else if (out_valid && (abs_sat(audio_out) > peak)) peak <= abs_sat(audio_out);
   end

   assign peak_out = peak;
`endif

endmodule

// File: tb/tb_audio_fx_router.sv
// Bench for audio_fx_router: hand vector table, reset-mid-fade sequence and random traffic vs. a reference model.
module tb_audio_fx_router;
   localparam int DATA_W    = 16;
   localparam int N_FX      = 2;
   localparam int RAMP_LOG2 = 2;
   localparam int M         = 4;

   logic clk_25mhz = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   audio_fx_router_if #(.DATA_W(DATA_W), .N_FX(N_FX)) bus ();

`ifdef AUDIO_FX_ROUTER_PEAK_EN
   logic [DATA_W-2:0] peak_out;
`endif

   audio_fx_router #(
      .DATA_W    (DATA_W),
      .N_FX      (N_FX),
      .RAMP_LOG2 (RAMP_LOG2)
   ) dut (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .bus       (bus)
`ifdef AUDIO_FX_ROUTER_PEAK_EN
      ,
      .peak_clr  (1'b0),
      .peak_out  (peak_out)
`endif
   );

   always #20 clk_25mhz = ~clk_25mhz;

   // Reference model: current source, fade target/position, pending request list.
   int   m_cur;
   int   m_tgt;
   int   m_pos;
   bit   m_fading;
   int   m_pend[$];
   bit   p1_v;
   int   p1_y;
   int   last_out;

   typedef struct {
      int dry;
      int w0;
      int w1;
      int sel;
      int exp_y;
      bit exp_busy;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int mix(input int a, input int b, input int k);
      int num;
      int q;
      num = a * (M - k) + b * k + M / 2;
      q   = num / M;
      if ((num % M) != 0 && num < 0) q = q - 1;
      return q;
   endfunction

   function automatic int pick(input int s, input int d, input int w0, input int w1);
      if (s == 1) return w0;
      else if (s == 2) return w1;
      else return d;
   endfunction

   task automatic model_reset();
      m_cur    = 0;
      m_tgt    = 0;
      m_pos    = 0;
      m_fading = 1'b0;
      m_pend.delete();
      p1_v     = 1'b0;
      p1_y     = 0;
      last_out = 0;
   endtask

   task automatic model_sample(input int d, input int w0, input int w1, input int s, output int y);
      int e;
      e = (s > N_FX) ? 0 : s;
      if (!m_fading && e != m_cur) begin
         m_fading = 1'b1;
         m_tgt    = e;
         m_pos    = 1;
      end else if (m_fading) begin
         m_pend.delete();
         if (e != m_tgt) m_pend.push_back(e);
      end
      if (m_fading) begin
         y = mix(pick(m_cur, d, w0, w1), pick(m_tgt, d, w0, w1), m_pos);
         if (m_pos == M) begin
            m_cur    = m_tgt;
            m_fading = 1'b0;
            m_pos    = 0;
            if (m_pend.size() > 0) begin
               m_tgt    = m_pend.pop_front();
               m_fading = 1'b1;
               m_pos    = 1;
            end
         end else begin
            m_pos++;
         end
      end else begin
         y = pick(m_cur, d, w0, w1);
      end
   endtask

   task automatic cycle(input bit iv, input int d, input int w0, input int w1, input int s,
                        input string tag);
      int y;
      y = 0;
      bus.in_valid = iv;
      bus.dry_in   = 16'(d);
      bus.wet_in   = {16'(w1), 16'(w0)};
      bus.fx_sel   = 2'(s);
      if (iv) model_sample(d, w0, w1, s, y);
      @(posedge clk_25mhz);
      #1;
      if (p1_v) last_out = p1_y;
      check({tag, "_vld"},  int'(bus.out_valid), int'(p1_v));
      check({tag, "_out"},  int'(bus.audio_out), last_out);
      check({tag, "_busy"}, int'(bus.busy), int'(m_fading || (m_pend.size() > 0)));
      p1_v = iv;
      p1_y = y;
   endtask

   task automatic add(input int d, input int w0, input int w1, input int s, input int y, input bit b);
      vec_t v;
      v.dry = d; v.w0 = w0; v.w1 = w1; v.sel = s; v.exp_y = y; v.exp_busy = b;
      tbl.push_back(v);
   endtask

   function automatic int rnd_sample();
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) return -32768;
      if (r == 1) return 32767;
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   initial begin
      int t4_exp[5];
      int sel;
      bit iv;

      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.dry_in   = '0;
      bus.wet_in   = '0;
      bus.fx_sel   = '0;
      model_reset();
      repeat (2) @(posedge clk_25mhz);
      #1;
      check("rst_vld",  int'(bus.out_valid), 0);
      check("rst_out",  int'(bus.audio_out), 0);
      check("rst_busy", int'(bus.busy), 0);
      reset = 1'b0;

      // Steady dry routing with sparse strobes
      for (int n = 0; n < 3; n++) begin
         cycle(1'b1, 1000, 0, 0, 0, "t1");
         repeat (7) cycle(1'b0, 1000, 0, 0, 0, "t1");
         check("t1_hold", int'(bus.audio_out), 1000);
      end

      add(1000, 0, 0, 0, 1000, 0);
      add(1000, 0, 0, 0, 1000, 0);
      add(0, 4000, 0, 1, 1000, 1);
      add(0, 4000, 0, 1, 2000, 1);
      add(0, 4000, 0, 1, 3000, 1);
      add(0, 4000, 0, 1, 4000, 0);
      add(0, 4000, 0, 1, 4000, 0);
      add(0, 4000, 0, 0, 3000, 1);
      add(0, 4000, 0, 0, 2000, 1);
      add(0, 4000, 0, 0, 1000, 1);
      add(0, 4000, 0, 0, 0, 0);
      add(0, 4000, 0, 0, 0, 0);
      add(0, 4000, -4000, 1, 1000, 1);
      add(0, 4000, -4000, 2, 2000, 1);
      add(0, 4000, -4000, 2, 3000, 1);
      add(0, 4000, -4000, 2, 4000, 1);
      add(0, 4000, -4000, 2, 2000, 1);
      add(0, 4000, -4000, 2, 0, 1);
      add(0, 4000, -4000, 2, -2000, 1);
      add(0, 4000, -4000, 2, -4000, 0);
      add(0, 4000, -4000, 2, -4000, 0);
      add(0, 4000, -4000, 0, -3000, 1);
      add(0, 4000, -4000, 0, -2000, 1);
      add(0, 4000, -4000, 0, -1000, 1);
      add(0, 4000, -4000, 0, 0, 0);
      add(0, 4000, -4000, 0, 0, 0);
      add(-32768, 32767, 0, 1, -16384, 1);
      add(-32768, 32767, 0, 1, 0, 1);
      add(-32768, 32767, 0, 1, 16383, 1);
      add(-32768, 32767, 0, 1, 32767, 0);
      add(-32768, 32767, 0, 1, 32767, 0);
      add(0, 32767, 0, 0, 24575, 1);
      add(0, 32767, 0, 0, 16384, 1);
      add(0, 32767, 0, 0, 8192, 1);
      add(0, 32767, 0, 0, 0, 0);
      add(1234, 32767, 0, 3, 1234, 0);
      add(-5, 32767, 0, 3, -5, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(1'b1, tbl[i].dry, tbl[i].w0, tbl[i].w1, tbl[i].sel, "tbl");
         cycle(1'b0, tbl[i].dry, tbl[i].w0, tbl[i].w1, tbl[i].sel, "tbl");
         check($sformatf("tbl_y%0d", i), int'(bus.audio_out), tbl[i].exp_y);
         check($sformatf("tbl_busy%0d", i), int'(bus.busy), int'(tbl[i].exp_busy));
      end

      // Reset while the fade sits at k=3
      cycle(1'b1, 100, 500, 0, 0, "t4");
      repeat (3) cycle(1'b1, 100, 500, 0, 1, "t4");
      #4;
      reset = 1'b1;
      #1;
      check("t4_rst_vld",  int'(bus.out_valid), 0);
      check("t4_rst_out",  int'(bus.audio_out), 0);
      check("t4_rst_busy", int'(bus.busy), 0);
      model_reset();
      bus.in_valid = 1'b0;
      @(posedge clk_25mhz);
      #5;
      reset = 1'b0;
      t4_exp = '{200, 300, 400, 500, 500};
      for (int j = 0; j < 5; j++) begin
         cycle(1'b1, 100, 500, 0, 1, "t4");
         cycle(1'b0, 100, 500, 0, 1, "t4");
         check($sformatf("t4_y%0d", j), int'(bus.audio_out), t4_exp[j]);
      end

      // Random traffic, including back-to-back strobes and mid-fade retargets
      sel = 1;
      for (int n = 0; n < 1500; n++) begin
         iv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) sel = int'($urandom_range(0, 3));
         cycle(iv, rnd_sample(), rnd_sample(), rnd_sample(), sel, "rnd");
      end
      repeat (3) cycle(1'b0, 0, 0, 0, sel, "drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
